elevator_scan_ctrl: RTL and testbench

- Parametrised successor to the single-request elevator controller.
- Latches any number of hall calls (up and down) and car calls, and serves them in collective SCAN order: keep the travel direction while calls remain ahead, then reverse.
- Adds a per-floor travel timer, a door-dwell phase and visible pending-call masks.
- Sits between the hall/car button decoders and the motor/door drivers of one car.

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elevator_call_reg.sv | 97 +++++++++
 rtl/elevator_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types for the SCAN elevator controller: travel direction, FSM state
// and the floor-index width helper.
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MOVE = 2'b01,
    DOOR = 2'b10
  } state_e;

  function automatic int floor_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/elevator_call_reg.sv
// Pending-call store for one car: up/down/car masks with clear-over-set priority,
// plus above/below/here/ahead/behind reductions for a queried floor.
module elevator_call_reg
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = 10,
  parameter int FLOOR_W  = floor_w(N_FLOORS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_FLOORS-1:0] set_up_i,
  input  logic [N_FLOORS-1:0] set_down_i,
  input  logic [N_FLOORS-1:0] set_car_i,
  input  logic [FLOOR_W-1:0]  floor_i,
  input  dir_e                dir_i,
  input  logic                serve_i,
  input  logic                serve_up_i,
  input  logic                serve_down_i,
  input  logic                serve_car_i,
  output logic [N_FLOORS-1:0] pend_up_o,
  output logic [N_FLOORS-1:0] pend_down_o,
  output logic [N_FLOORS-1:0] pend_car_o,
  output logic                above_o,
  output logic                below_o,
  output logic                here_o,
  output logic                ahead_o,
  output logic                behind_o,
  output logic                here_up_o,
  output logic                here_down_o,
  output logic                here_car_o
);

  // No up call exists at the top floor and no down call at the bottom floor.
  localparam logic [N_FLOORS-1:0] UP_MASK   = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DOWN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  logic [N_FLOORS-1:0] pend_up_q, pend_up_d;
  logic [N_FLOORS-1:0] pend_down_q, pend_down_d;
  logic [N_FLOORS-1:0] pend_car_q, pend_car_d;
  logic [N_FLOORS-1:0] any_q, sel;
  logic [N_FLOORS-1:0] clr_up, clr_down, clr_car;

  assign any_q = pend_up_q | pend_down_q | pend_car_q;

  always_comb begin
    sel     = '0;
    above_o = 1'b0;
    below_o = 1'b0;
    for (int f = 0; f < N_FLOORS; f++) begin
      if (f == int'(floor_i)) sel[f] = 1'b1;
      if (f > int'(floor_i))  above_o = above_o | any_q[f];
      if (f < int'(floor_i))  below_o = below_o | any_q[f];
    end
  end

  assign here_up_o   = |(pend_up_q & sel);
  assign here_down_o = |(pend_down_q & sel);
  assign here_car_o  = |(pend_car_q & sel);
  assign here_o      = here_up_o | here_down_o | here_car_o;

  always_comb begin
    ahead_o  = 1'b0;
    behind_o = 1'b0;
    case (dir_i)
      DIR_UP:   begin ahead_o = above_o; behind_o = below_o; end
      DIR_DOWN: begin ahead_o = below_o; behind_o = above_o; end
      default:  begin ahead_o = 1'b0;    behind_o = 1'b0;    end
    endcase
  end

  // A serve on the same edge as a new request clears it: the call is served.
  always_comb begin
    clr_up      = (serve_i && serve_up_i)   ? sel : '0;
    clr_down    = (serve_i && serve_down_i) ? sel : '0;
    clr_car     = (serve_i && serve_car_i)  ? sel : '0;
    pend_up_d   = (pend_up_q   | (set_up_i & UP_MASK))     & ~clr_up;
    pend_down_d = (pend_down_q | (set_down_i & DOWN_MASK)) & ~clr_down;
    pend_car_d  = (pend_car_q  | set_car_i)                & ~clr_car;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_up_q   <= '0;
      pend_down_q <= '0;
      pend_car_q  <= '0;
    end else begin
      pend_up_q   <= pend_up_d;
      pend_down_q <= pend_down_d;
      pend_car_q  <= pend_car_d;
    end
  end

  assign pend_up_o   = pend_up_q;
  assign pend_down_o = pend_down_q;
  assign pend_car_o  = pend_car_q;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Collective SCAN controller for one car: keeps direction while calls remain
// ahead, stops for car calls and same-direction hall calls, then reverses.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS      = 10,
  parameter int FLOOR_W       = floor_w(N_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3,
  parameter int RESET_FLOOR   = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_FLOORS-1:0] hall_up_i,
  input  logic [N_FLOORS-1:0] hall_down_i,
  input  logic [N_FLOORS-1:0] car_call_i,
  output logic [FLOOR_W-1:0]  floor_o,
  output logic [1:0]          direction_o,
  output logic                door_open_o,
  output logic                arrived_o,
  output logic [N_FLOORS-1:0] pend_up_o,
  output logic [N_FLOORS-1:0] pend_down_o,
  output logic [N_FLOORS-1:0] pend_car_o,
  output state_e              state_o
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0]      TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]      DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] RST_FLOOR   = FLOOR_W'(RESET_FLOOR);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic [TW-1:0]       travel_q, travel_d;
  logic [DW-1:0]       door_q, door_d;
  logic                arrived_q, arrived_d;

  logic serve, serve_up, serve_down, serve_car, stop;
  logic above, below, here, ahead, behind, here_up, here_down, here_car;

  // Decode is taken at floor_d so a stop is judged at the floor just reached.
  elevator_call_reg #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) u_call_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .set_up_i     (hall_up_i),
    .set_down_i   (hall_down_i),
    .set_car_i    (car_call_i),
    .floor_i      (floor_d),
    .dir_i        (dir_q),
    .serve_i      (serve),
    .serve_up_i   (serve_up),
    .serve_down_i (serve_down),
    .serve_car_i  (serve_car),
    .pend_up_o    (pend_up_o),
    .pend_down_o  (pend_down_o),
    .pend_car_o   (pend_car_o),
    .above_o      (above),
    .below_o      (below),
    .here_o       (here),
    .ahead_o      (ahead),
    .behind_o     (behind),
    .here_up_o    (here_up),
    .here_down_o  (here_down),
    .here_car_o   (here_car)
  );

  always_comb begin
    floor_d = floor_q;
    if (state_q == MOVE && travel_q == '0) begin
      if (dir_q == DIR_UP && floor_q != TOP_FLOOR)       floor_d = floor_q + FLOOR_W'(1);
      else if (dir_q == DIR_DOWN && floor_q != '0)       floor_d = floor_q - FLOOR_W'(1);
    end
  end

  assign stop = here_car | ((dir_q == DIR_UP) ? here_up : here_down) |
                (!ahead && (here_up || here_down));

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    travel_d   = travel_q;
    door_d     = door_q;
    serve      = 1'b0;
    serve_up   = 1'b0;
    serve_down = 1'b0;
    serve_car  = 1'b0;
    case (state_q)
      IDLE: begin
        dir_d = DIR_IDLE;
        if (here) begin
          state_d = DOOR;
          door_d  = DOOR_LOAD;
        end else if (above) begin
          state_d  = MOVE;
          dir_d    = DIR_UP;
          travel_d = TRAVEL_LOAD;
        end else if (below) begin
          state_d  = MOVE;
          dir_d    = DIR_DOWN;
          travel_d = TRAVEL_LOAD;
        end
      end
      MOVE: begin
        if (travel_q != '0) begin
          travel_d = travel_q - TW'(1);
        end else if (stop) begin
          state_d = DOOR;
          door_d  = DOOR_LOAD;
        end else if (ahead) begin
          travel_d = TRAVEL_LOAD;
        end else begin
          state_d = IDLE;
          dir_d   = DIR_IDLE;
        end
      end
      DOOR: begin
        if (door_q != '0) begin
          door_d = door_q - DW'(1);
        end else if (ahead) begin
          state_d  = MOVE;
          travel_d = TRAVEL_LOAD;
        end else if (behind) begin
          state_d  = MOVE;
          dir_d    = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
          travel_d = TRAVEL_LOAD;
        end else begin
          state_d = IDLE;
          dir_d   = DIR_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        dir_d   = DIR_IDLE;
      end
    endcase

    // While the door is (or is about to be) open, matching calls at this floor are served.
    if (state_d == DOOR) begin
      serve     = 1'b1;
      serve_car = 1'b1;
      case (dir_q)
        DIR_UP:   begin serve_up = 1'b1;  serve_down = !ahead; end
        DIR_DOWN: begin serve_down = 1'b1; serve_up = !ahead;  end
        default:  begin serve_up = 1'b1;  serve_down = 1'b1;   end
      endcase
    end
  end

  assign arrived_d = (state_d == DOOR) && (state_q != DOOR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      dir_q     <= DIR_IDLE;
      floor_q   <= RST_FLOOR;
      travel_q  <= '0;
      door_q    <= '0;
      arrived_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      travel_q  <= travel_d;
      door_q    <= door_d;
      arrived_q <= arrived_d;
    end
  end

  assign floor_o     = floor_q;
  assign direction_o = dir_q;
  assign door_open_o = (state_q == DOOR);
  assign arrived_o   = arrived_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl with default parameters
// (10 floors, 4 cycles per floor, 3-cycle dwell, reset floor 0).
module tb_elevator_scan_ctrl;
  import elevator_pkg::*;

  localparam int N  = 10;
  localparam int FW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [N-1:0]  hall_up_i   = '0;
  logic [N-1:0]  hall_down_i = '0;
  logic [N-1:0]  car_call_i  = '0;
  logic [FW-1:0] floor_o;
  logic [1:0]    direction_o;
  logic          door_open_o;
  logic          arrived_o;
  logic [N-1:0]  pend_up_o, pend_down_o, pend_car_o;
  state_e        state_o;

  int n_vec     = 0;
  int n_bad     = 0;
  int n_arrived = 0;
  int a0        = 0;

  elevator_scan_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hall_up_i   (hall_up_i),
    .hall_down_i (hall_down_i),
    .car_call_i  (car_call_i),
    .floor_o     (floor_o),
    .direction_o (direction_o),
    .door_open_o (door_open_o),
    .arrived_o   (arrived_o),
    .pend_up_o   (pend_up_o),
    .pend_down_o (pend_down_o),
    .pend_car_o  (pend_car_o),
    .state_o     (state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (rst_i && arrived_o) n_arrived++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  function automatic logic [N-1:0] bit_at(input int k);
    logic [N-1:0] one;
    one = N'(1);
    return one << k;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] up, input logic [N-1:0] dn, input logic [N-1:0] car);
    hall_up_i   = up;
    hall_down_i = dn;
    car_call_i  = car;
    step(1);
    hall_up_i   = '0;
    hall_down_i = '0;
    car_call_i  = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic settle(input string tag, input int budget);
    int  k;
    logic ok;
    k  = 0;
    ok = 1'b0;
    while (k < budget && !ok) begin
      ok = (state_o == IDLE) && !door_open_o && pend_up_o == '0 &&
           pend_down_o == '0 && pend_car_o == '0;
      if (!ok) begin
        step(1);
        k++;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    step(2);
    check("rst_floor",   32'(floor_o), 32'd0);
    check("rst_dir",     32'(direction_o), 32'd0);
    check("rst_door",    32'(door_open_o), 32'd0);
    check("rst_arrived", 32'(arrived_o), 32'd0);
    check("rst_pend",    32'(pend_up_o | pend_down_o | pend_car_o), 32'd0);
    check("rst_state",   32'(state_o), 32'(IDLE));
    rst_i = 1'b1;
    step(1);

    // 1: single up call at floor 4 from floor 0
    a0 = n_arrived;
    pulse(bit_at(4), '0, '0);
    check("t1_latch", 32'(pend_up_o), 32'(bit_at(4)));
    check("t1_dir0",  32'(direction_o), 32'd0);
    step(1);
    check("t1_dir_up",   32'(direction_o), 32'd1);
    check("t1_state_mv", 32'(state_o), 32'(MOVE));
    step(3);
    check("t1_f0_hold", 32'(floor_o), 32'd0);
    step(1);
    check("t1_f1", 32'(floor_o), 32'd1);
    step(4);
    check("t1_f2", 32'(floor_o), 32'd2);
    step(8);
    check("t1_f4",      32'(floor_o), 32'd4);
    check("t1_arr",     32'(arrived_o), 32'd1);
    check("t1_door",    32'(door_open_o), 32'd1);
    check("t1_pend_up", 32'(pend_up_o), 32'd0);
    step(1);
    check("t1_arr_pulse", 32'(arrived_o), 32'd0);
    check("t1_door2",     32'(door_open_o), 32'd1);
    step(1);
    check("t1_door3", 32'(door_open_o), 32'd1);
    step(1);
    check("t1_door_off", 32'(door_open_o), 32'd0);
    check("t1_idle",     32'(state_o), 32'(IDLE));
    check("t1_dir_idle", 32'(direction_o), 32'd0);
    check("t1_arr_cnt",  32'(n_arrived - a0), 32'd1);

    // 2: car call 9 + hall up 6 from floor 4
    a0 = n_arrived;
    pulse(bit_at(6), '0, bit_at(9));
    check("t2_car", 32'(pend_car_o), 32'(bit_at(9)));
    check("t2_up",  32'(pend_up_o), 32'(bit_at(6)));
    step(1);
    check("t2_dir", 32'(direction_o), 32'd1);
    step(8);
    check("t2_f6",     32'(floor_o), 32'd6);
    check("t2_arr6",   32'(arrived_o), 32'd1);
    check("t2_up_clr", 32'(pend_up_o), 32'd0);
    check("t2_car9",   32'(pend_car_o), 32'(bit_at(9)));
    step(3);
    check("t2_resume", 32'(state_o), 32'(MOVE));
    step(12);
    check("t2_f9",   32'(floor_o), 32'd9);
    check("t2_arr9", 32'(arrived_o), 32'd1);
    step(3);
    check("t2_idle",    32'(state_o), 32'(IDLE));
    check("t2_masks",   32'(pend_up_o | pend_down_o | pend_car_o), 32'd0);
    check("t2_arr_cnt", 32'(n_arrived - a0), 32'd2);

    // 3: go to floor 2, then up to 9 with a down call at 6 latched en route
    pulse('0, '0, bit_at(2));
    settle("t3_settle_f2", 200);
    check("t3_at2", 32'(floor_o), 32'd2);
    pulse('0, '0, bit_at(9));
    step(1);
    check("t3_dir_up", 32'(direction_o), 32'd1);
    step(12);
    check("t3_f5", 32'(floor_o), 32'd5);
    pulse('0, bit_at(6), '0);
    check("t3_dn6", 32'(pend_down_o), 32'(bit_at(6)));
    step(3);
    check("t3_pass6",  32'(floor_o), 32'd6);
    check("t3_nostop", 32'(state_o), 32'(MOVE));
    step(12);
    check("t3_f9",   32'(floor_o), 32'd9);
    check("t3_arr9", 32'(arrived_o), 32'd1);
    step(3);
    check("t3_rev",   32'(direction_o), 32'd2);
    check("t3_rev_mv", 32'(state_o), 32'(MOVE));
    step(12);
    check("t3_f6",      32'(floor_o), 32'd6);
    check("t3_arr6",    32'(arrived_o), 32'd1);
    check("t3_dn_clr",  32'(pend_down_o), 32'd0);
    check("t3_dir_hold", 32'(direction_o), 32'd2);
    settle("t3_settle", 50);

    // 4: call at the current floor while idle at 3
    pulse('0, '0, bit_at(3));
    settle("t4_settle_f3", 200);
    check("t4_at3", 32'(floor_o), 32'd3);
    pulse(bit_at(3), '0, '0);
    check("t4_latch",  32'(pend_up_o), 32'(bit_at(3)));
    check("t4_door_lo", 32'(door_open_o), 32'd0);
    step(1);
    check("t4_door_hi", 32'(door_open_o), 32'd1);
    check("t4_floor",   32'(floor_o), 32'd3);
    check("t4_dir",     32'(direction_o), 32'd0);
    check("t4_served",  32'(pend_up_o), 32'd0);
    pulse('0, '0, bit_at(3));
    check("t4_dwell_serve", 32'(pend_car_o), 32'd0);
    check("t4_door_d2",     32'(door_open_o), 32'd1);
    step(1);
    check("t4_door_d3", 32'(door_open_o), 32'd1);
    step(1);
    check("t4_no_extend", 32'(door_open_o), 32'd0);

    // 5: out-of-range hall buttons are ignored
    pulse(bit_at(9), bit_at(0), '0);
    check("t5_up9",   32'(pend_up_o), 32'd0);
    check("t5_dn0",   32'(pend_down_o), 32'd0);
    step(2);
    check("t5_idle",  32'(state_o), 32'(IDLE));
    check("t5_floor", 32'(floor_o), 32'd3);

    // 6: asynchronous reset while moving from 2 toward 3
    pulse('0, '0, bit_at(2));
    settle("t6_settle_f2", 200);
    pulse('0, '0, bit_at(3) | bit_at(8));
    step(2);
    check("t6_moving", 32'(state_o), 32'(MOVE));
    #2;
    rst_i = 1'b0;
    #1;
    check("t6_floor", 32'(floor_o), 32'd0);
    check("t6_dir",   32'(direction_o), 32'd0);
    check("t6_state", 32'(state_o), 32'(IDLE));
    check("t6_door",  32'(door_open_o), 32'd0);
    check("t6_pend",  32'(pend_car_o), 32'd0);
    step(1);
    rst_i = 1'b1;
    step(2);
    check("t6_stay_idle", 32'(state_o), 32'(IDLE));
    check("t6_stay_f0",   32'(floor_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
